// File: rtl/window_mac_array_if.sv
// rtl/window_mac_array_if.sv - element/weight input and neuron result bundle for window_mac_array
interface window_mac_array_if;
   logic        clear;
   logic        a_element_ready;
   logic [15:0] a0_element;
   logic [15:0] a1_element;
   logic [15:0] a2_element;
   logic [15:0] a3_element;
   logic [15:0] weight_element;
   logic [15:0] bias;
   logic        result_valid;
   logic [15:0] result0;
   logic [15:0] result1;
   logic [15:0] result2;
   logic [15:0] result3;
   logic [3:0]  saturated;
   logic        busy;

   modport master (
      output clear, a_element_ready, a0_element, a1_element, a2_element, a3_element,
             weight_element, bias,
      input  result_valid, result0, result1, result2, result3, saturated, busy
   );

   modport slave (
      input  clear, a_element_ready, a0_element, a1_element, a2_element, a3_element,
             weight_element, bias,
      output result_valid, result0, result1, result2, result3, saturated, busy
   );
endinterface

// File: rtl/window_mac_array.sv
// rtl/window_mac_array.sv - four-lane Q8.8 windowed MAC with bias, optional ReLU, round and saturate
module window_mac_array #(
   parameter int WINDOW_LEN = 9,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 36,
   parameter bit RELU_EN    = 1'b1
) (
   input  logic              clock,
   input  logic              clear_n,
   window_mac_array_if.slave bus
);
   localparam int CNT_W = $clog2(WINDOW_LEN);
   localparam logic [CNT_W-1:0]            LAST_CNT  = CNT_W'(WINDOW_LEN - 1);
   localparam logic signed [ACC_WIDTH-1:0] RND_CONST = ACC_WIDTH'(2 ** (FRAC_BITS - 1));
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX   = ACC_WIDTH'(32767);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN   = ACC_WIDTH'(-32768);

   logic signed [15:0] w_a [4];
   logic signed [15:0] w_weight;
   logic               w_accept;
   logic               w_last_in;

   logic [CNT_W-1:0]       r_count;
   logic signed [31:0]     r_prod [4];
   logic                   r_prod_valid;
   logic                   r_prod_first;
   logic                   r_prod_last;
   logic signed [15:0]     r_bias;
   logic signed [ACC_WIDTH-1:0] r_acc [4];
   logic                   r_finish;
   logic signed [15:0]     r_result [4];
   logic [3:0]             r_saturated;
   logic                   r_result_valid;

   logic signed [ACC_WIDTH-1:0] w_round [4];
   logic signed [ACC_WIDTH-1:0] w_sum [4];
   logic signed [15:0]          w_res [4];
   logic [3:0]                  w_sat;

   assign w_a[0]    = bus.a0_element;
   assign w_a[1]    = bus.a1_element;
   assign w_a[2]    = bus.a2_element;
   assign w_a[3]    = bus.a3_element;
   assign w_weight  = bus.weight_element;
   assign w_accept  = bus.a_element_ready & ~bus.clear;
   assign w_last_in = (r_count == LAST_CNT);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_count <= '0;
      end else if (bus.clear) begin
         r_count <= '0;
      end else if (bus.a_element_ready) begin
         r_count <= w_last_in ? '0 : r_count + 1'b1;
      end
   end

   // Stage 1: lane products plus window position tags; bias captured with the last element
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_prod_valid <= 1'b0;
         r_prod_first <= 1'b0;
         r_prod_last  <= 1'b0;
         r_bias       <= '0;
         for (int i = 0; i < 4; i++) r_prod[i] <= '0;
      end else begin
         r_prod_valid <= w_accept;
         if (w_accept) begin
            r_prod_first <= (r_count == '0);
            r_prod_last  <= w_last_in;
            if (w_last_in) r_bias <= bus.bias;
            for (int i = 0; i < 4; i++)
               r_prod[i] <= $signed(32'(w_a[i])) * $signed(32'(w_weight));
         end
      end
   end

   // Stage 2: first product loads, later ones add; clear drops the product in flight
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_finish <= 1'b0;
         for (int i = 0; i < 4; i++) r_acc[i] <= '0;
      end else begin
         r_finish <= r_prod_valid & r_prod_last & ~bus.clear;
         if (r_prod_valid && !bus.clear) begin
            for (int i = 0; i < 4; i++)
               r_acc[i] <= r_prod_first ? ACC_WIDTH'(r_prod[i])
                                        : r_acc[i] + ACC_WIDTH'(r_prod[i]);
         end
      end
   end

   // Stage 3 reads the finished accumulators combinationally on the same edge the next
   // window's first product reloads them, so the registered result is the snapshot.
   always_comb begin
      w_sat = '0;
      for (int i = 0; i < 4; i++) begin
         w_round[i] = (r_acc[i] + RND_CONST) >>> FRAC_BITS;
         w_sum[i]   = w_round[i] + ACC_WIDTH'(r_bias);
         if (RELU_EN && w_sum[i][ACC_WIDTH-1]) begin
            w_res[i] = '0;
         end else if (w_sum[i] > SAT_MAX) begin
            w_res[i] = 16'sh7FFF;
            w_sat[i] = 1'b1;
         end else if (w_sum[i] < SAT_MIN) begin
            w_res[i] = 16'sh8000;
            w_sat[i] = 1'b1;
         end else begin
            w_res[i] = w_sum[i][15:0];
         end
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_result_valid <= 1'b0;
         r_saturated    <= '0;
         for (int i = 0; i < 4; i++) r_result[i] <= '0;
      end else begin
         r_result_valid <= r_finish;
         if (r_finish) begin
            r_saturated <= w_sat;
            for (int i = 0; i < 4; i++) r_result[i] <= w_res[i];
         end
      end
   end

   assign bus.result_valid = r_result_valid;
   assign bus.result0      = r_result[0];
   assign bus.result1      = r_result[1];
   assign bus.result2      = r_result[2];
   assign bus.result3      = r_result[3];
   assign bus.saturated    = r_saturated;
   assign bus.busy         = (r_count != '0) | r_prod_valid | r_finish;
endmodule

// File: tb/tb_window_mac_array.sv
// tb/tb_window_mac_array.sv - randomized self-checking bench for window_mac_array (ReLU on and off)
module tb_window_mac_array;
   localparam int W = 9;

   logic clock = 1'b0;
   logic clear_n;
   always #5 clock = ~clock;

   logic        t_clear, t_ready;
   logic [15:0] t_a [4];
   logic [15:0] t_w, t_bias;

   window_mac_array_if bus_r ();
   window_mac_array_if bus_n ();

   assign bus_r.clear = t_clear;           assign bus_n.clear = t_clear;
   assign bus_r.a_element_ready = t_ready; assign bus_n.a_element_ready = t_ready;
   assign bus_r.a0_element = t_a[0];       assign bus_n.a0_element = t_a[0];
   assign bus_r.a1_element = t_a[1];       assign bus_n.a1_element = t_a[1];
   assign bus_r.a2_element = t_a[2];       assign bus_n.a2_element = t_a[2];
   assign bus_r.a3_element = t_a[3];       assign bus_n.a3_element = t_a[3];
   assign bus_r.weight_element = t_w;      assign bus_n.weight_element = t_w;
   assign bus_r.bias = t_bias;             assign bus_n.bias = t_bias;

   window_mac_array #(.WINDOW_LEN(W), .FRAC_BITS(8), .ACC_WIDTH(36), .RELU_EN(1'b1))
      dut_r (.clock(clock), .clear_n(clear_n), .bus(bus_r));
   window_mac_array #(.WINDOW_LEN(W), .FRAC_BITS(8), .ACC_WIDTH(36), .RELU_EN(1'b0))
      dut_n (.clock(clock), .clear_n(clear_n), .bus(bus_n));

   logic [15:0] o_r [4];
   logic [15:0] o_n [4];
   assign o_r[0] = bus_r.result0; assign o_r[1] = bus_r.result1;
   assign o_r[2] = bus_r.result2; assign o_r[3] = bus_r.result3;
   assign o_n[0] = bus_n.result0; assign o_n[1] = bus_n.result1;
   assign o_n[2] = bus_n.result2; assign o_n[3] = bus_n.result3;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: per-lane window sums in plain integers, result due two edges after the last element.
   typedef struct packed {
      int              due;
      logic [3:0][15:0] rr;
      logic [3:0]       sr;
      logic [3:0][15:0] rn;
      logic [3:0]       sn;
   } exp_t;

   exp_t   q[$];
   int     cyc = 0;
   int     m_cnt = 0;
   longint m_sum [4];
   bit     run_mon = 1'b0;

   function automatic void finish_lane(input longint s, input logic [15:0] b, input bit relu,
                                       output logic [15:0] r, output logic sat);
      longint v;
      v = s + 128;
      v = (v >= 0) ? v / 256 : -((-v + 255) / 256);
      v = v + longint'($signed(b));
      sat = 1'b0;
      if (relu && v < 0) v = 0;
      if (v > 32767) begin v = 32767; sat = 1'b1; end
      else if (v < -32768) begin v = -32768; sat = 1'b1; end
      r = v[15:0];
   endfunction

   always @(posedge clock) begin
      exp_t        e;
      longint      p;
      logic [15:0] rv;
      logic        sv;
      cyc++;
      if (!clear_n) begin
         m_cnt = 0;
         q.delete();
      end else if (t_clear) begin
         m_cnt = 0;
         while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      end else if (t_ready) begin
         for (int i = 0; i < 4; i++) begin
            p = longint'($signed(t_a[i])) * longint'($signed(t_w));
            m_sum[i] = (m_cnt == 0) ? p : m_sum[i] + p;
         end
         if (m_cnt == W - 1) begin
            e.due = cyc + 2;
            for (int i = 0; i < 4; i++) begin
               finish_lane(m_sum[i], t_bias, 1'b1, rv, sv); e.rr[i] = rv; e.sr[i] = sv;
               finish_lane(m_sum[i], t_bias, 1'b0, rv, sv); e.rn[i] = rv; e.sn[i] = sv;
            end
            q.push_back(e);
         end
         m_cnt = (m_cnt + 1) % W;
      end
   end

   always @(negedge clock) begin
      bit   ev;
      exp_t e;
      if (run_mon) begin
         ev = (q.size() > 0) && (q[0].due == cyc);
         check("valid_relu", bus_r.result_valid, ev);
         check("valid_norelu", bus_n.result_valid, ev);
         if (ev) begin
            e = q.pop_front();
            for (int i = 0; i < 4; i++) begin
               check($sformatf("result%0d_relu", i), o_r[i], e.rr[i]);
               check($sformatf("result%0d_norelu", i), o_n[i], e.rn[i]);
            end
            check("sat_relu", bus_r.saturated, e.sr);
            check("sat_norelu", bus_n.saturated, e.sn);
         end
      end
   end

   task automatic put(input logic rdy, input logic clr, input logic [15:0] a0, a1, a2, a3,
                      input logic [15:0] w, input logic [15:0] b);
      t_ready = rdy; t_clear = clr;
      t_a[0] = a0; t_a[1] = a1; t_a[2] = a2; t_a[3] = a3;
      t_w = w; t_bias = b;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) put(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic uni_window(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b,
                             input bit gapped);
      for (int k = 0; k < W; k++) begin
         put(1'b1, 1'b0, a, a, a, a, w, b);
         if (gapped && k < W - 1) idle(2);
      end
   endtask

   task automatic expect_all(input string tag, input logic [15:0] vr, input logic [15:0] vn);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_r%0d", tag, i), o_r[i], vr);
         check($sformatf("%s_n%0d", tag, i), o_n[i], vn);
      end
   endtask

   initial begin
      clear_n = 1'b0;
      t_clear = 1'b0; t_ready = 1'b0; t_w = '0; t_bias = '0;
      for (int i = 0; i < 4; i++) t_a[i] = '0;
      repeat (3) @(negedge clock);
      check("reset_valid", bus_r.result_valid, 1'b0);
      check("reset_busy", bus_r.busy, 1'b0);
      check("reset_sat", bus_r.saturated, 4'h0);
      expect_all("reset_res", 16'h0000, 16'h0000);
      clear_n = 1'b1;
      run_mon = 1'b1;

      // unity window
      uni_window(16'h0100, 16'h0100, 16'h0000, 1'b0);
      check("busy_tail", bus_r.busy, 1'b1);
      idle(3);
      check("busy_idle", bus_r.busy, 1'b0);
      expect_all("unity", 16'h0900, 16'h0900);
      check("unity_sat", bus_r.saturated, 4'h0);

      // rounding plus bias on lane 0
      for (int k = 0; k < W; k++)
         put(1'b1, 1'b0, (k == 0) ? 16'h0001 : 16'h0000, 16'hFF00, 16'h0100, 16'h0000,
             16'h0080, 16'h0100);
      idle(3);
      check("round_bias_r0", o_r[0], 16'h0101);

      // negative window: ReLU clamps, no-ReLU passes through
      uni_window(16'hFF00, 16'h0100, 16'h0000, 1'b0);
      idle(3);
      check("relu_r1", o_r[1], 16'h0000);
      check("norelu_r1", o_n[1], 16'hF700);
      check("relu_not_sat", bus_r.saturated, 4'h0);

      // positive and negative saturation
      uni_window(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0);
      idle(3);
      expect_all("sat_pos", 16'h7FFF, 16'h7FFF);
      check("sat_pos_flags", bus_r.saturated, 4'hF);
      uni_window(16'h8000, 16'h7FFF, 16'h0000, 1'b0);
      idle(3);
      expect_all("sat_neg", 16'h0000, 16'h8000);
      check("sat_neg_flags_n", bus_n.saturated, 4'hF);

      // gapped window followed by back-to-back window
      uni_window(16'h0100, 16'h0100, 16'h0000, 1'b1);
      uni_window(16'h0200, 16'h0100, 16'h0000, 1'b0);
      idle(3);
      expect_all("b2b", 16'h1200, 16'h1200);

      // clear mid-window
      for (int k = 0; k < 4; k++) put(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0);
      put(1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      check("busy_after_clear", bus_r.busy, 1'b0);
      uni_window(16'h0100, 16'h0100, 16'h0000, 1'b0);
      idle(3);
      expect_all("clear_mid", 16'h0900, 16'h0900);

      // clear coincident with ready
      for (int k = 0; k < 3; k++) put(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0);
      put(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0);
      uni_window(16'h0100, 16'h0100, 16'h0000, 1'b0);
      idle(3);
      expect_all("clear_coinc", 16'h0900, 16'h0900);

      // async reset during element 5
      for (int k = 0; k < 4; k++) put(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0);
      t_ready = 1'b1;
      #3 clear_n = 1'b0;
      #1;
      expect_all("areset", 16'h0000, 16'h0000);
      check("areset_busy", bus_r.busy, 1'b0);
      check("areset_valid", bus_r.result_valid, 1'b0);
      @(negedge clock);
      clear_n = 1'b1;
      idle(1);
      uni_window(16'h0100, 16'h0100, 16'h0000, 1'b0);
      idle(3);
      expect_all("after_areset", 16'h0900, 16'h0900);

      // randomized traffic with gaps, occasional clears and mixed magnitudes
      repeat (400) begin
         int          r;
         logic [15:0] ra [4];
         logic [15:0] rw, rb;
         r = $urandom_range(0, 99);
         for (int i = 0; i < 4; i++)
            ra[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
         rw = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
         rb = 16'($urandom);
         put(r < 75, r < 3, ra[0], ra[1], ra[2], ra[3], rw, rb);
      end
      idle(4);
      check("drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
